// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN       = 32;
  localparam int ITER_CNT_W = 6;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> muldiv bundle. start/op/operands are sampled only when the unit is idle;
// done is a one-cycle pulse qualifying result, and stall holds the front end while busy.
interface ex_muldiv_unit_if #(parameter int XLEN = muldiv_pkg::XLEN);
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;
  muldiv_state_e   state;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  busy, done, result, stall, state
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output busy, done, result, stall, state
  );
endinterface

// File: rtl/muldiv_divider.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor, keep the difference only when it does not borrow.
module muldiv_divider #(parameter int XLEN = muldiv_pkg::XLEN) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);
  import muldiv_pkg::*;

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  assign w_shifted = {i_rem, i_quo[XLEN-1]};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  assign o_rem     = w_diff[XLEN] ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_quo     = {i_quo[XLEN-2:0], ~w_diff[XLEN]};
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit (one bit per cycle) that stalls the front end while busy.
// Divide support is built only when EX_MUDIV_DIV_EN is defined; otherwise ops 4-7 return 0.
module ex_muldiv_unit #(parameter int XLEN = muldiv_pkg::XLEN) (
  input logic            clk,
  input logic            rst,
  ex_muldiv_unit_if.slave bus
);
  import muldiv_pkg::*;

  muldiv_state_e         r_state, w_next_state;
  muldiv_op_e            r_op, w_op;
  logic [ITER_CNT_W-1:0] r_cnt;
  logic                  r_neg_a, r_neg_b, r_special;
  logic [XLEN-1:0]       r_special_val, r_opnd, r_result;
  logic [2*XLEN-1:0]     r_acc;

  logic                  w_accept, w_last, w_busy, w_done, w_is_div;
  logic                  w_signed_a, w_signed_b, w_neg_a, w_neg_b, w_special;
  logic [XLEN-1:0]       w_mag_a, w_mag_b, w_special_val, w_mul_res, w_final;
  logic [XLEN:0]         w_mul_sum;
  logic [2*XLEN-1:0]     w_prod, w_acc_next;

  assign w_op       = muldiv_op_e'(bus.op);
  assign w_is_div   = bus.op[2];
  assign w_signed_a = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_signed_b = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_neg_a    = w_signed_a & bus.operand_a[XLEN-1];
  assign w_neg_b    = w_signed_b & bus.operand_b[XLEN-1];
  assign w_mag_a    = w_neg_a ? -bus.operand_a : bus.operand_a;
  assign w_mag_b    = w_neg_b ? -bus.operand_b : bus.operand_b;
  assign w_accept   = bus.start && !bus.flush && (r_state == ST_IDLE);
  assign w_last     = (r_cnt == ITER_CNT_W'(XLEN-1));

`ifdef EX_MUDIV_DIV_EN
  logic            w_div_zero, w_div_ovf;
  logic [XLEN-1:0] w_div_rem, w_div_quo;

  assign w_div_zero = (bus.operand_b == '0);
  assign w_div_ovf  = !bus.op[0] && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.operand_b == '1);
  assign w_special  = w_is_div && (w_div_zero || w_div_ovf);

  always_comb begin
    w_special_val = '1;
    if (w_div_zero) w_special_val = bus.op[1] ? bus.operand_a : '1;
    else            w_special_val = bus.op[1] ? '0 : bus.operand_a;
  end

  // Accumulator doubles as {partial remainder, dividend/quotient} during DIV.
  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .i_rem     (r_acc[2*XLEN-1:XLEN]),
    .i_quo     (r_acc[XLEN-1:0]),
    .i_divisor (r_opnd),
    .o_rem     (w_div_rem),
    .o_quo     (w_div_quo)
  );
`else
  assign w_special     = w_is_div;
  assign w_special_val = '0;
`endif

  // Shift-add: high half accumulates the multiplicand, low half shifts out multiplier bits.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  always_comb begin
    w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
`ifdef EX_MUDIV_DIV_EN
    if (r_state == ST_DIV) w_acc_next = {w_div_rem, w_div_quo};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_special) w_next_state = ST_DONE;
`ifdef EX_MUDIV_DIV_EN
          else if (w_is_div) w_next_state = ST_DIV;
`endif
          else w_next_state = ST_MUL;
        end
      end
      ST_MUL:  if (w_last) w_next_state = ST_DONE;
      ST_DIV:  if (w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (bus.flush) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op          <= OP_MUL;
      r_cnt         <= '0;
      r_neg_a       <= 1'b0;
      r_neg_b       <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_opnd        <= '0;
      r_acc         <= '0;
      r_result      <= '0;
    end else begin
      if (w_accept) begin
        r_op          <= w_op;
        r_cnt         <= '0;
        r_neg_a       <= w_neg_a;
        r_neg_b       <= w_neg_b;
        r_special     <= w_special;
        r_special_val <= w_special_val;
        r_opnd        <= w_is_div ? w_mag_b : w_mag_a;
        r_acc         <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      end else if (w_busy) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) r_result <= w_final;
    end
  end

  // Negating the whole {rem, quo} word yields -quo in the low half, so quotient reuses w_prod.
  assign w_prod    = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_comb begin
    w_final = w_mul_res;
`ifdef EX_MUDIV_DIV_EN
    if (r_op[2]) begin
      if (r_op[1]) w_final = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
      else         w_final = w_prod[XLEN-1:0];
    end
`endif
    if (r_special) w_final = r_special_val;
  end

  assign w_busy     = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_done     = (r_state == ST_DONE) && !bus.flush;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = w_done ? w_final : r_result;
  assign bus.stall  = w_accept | w_busy;
  assign bus.state  = r_state;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: per-cycle compare against a cycle-count/arithmetic
// model, directed literal cases, flush/reset kills and randomized back-to-back operations.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_muldiv_unit_if bus();

  ex_muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          m_age  = -1;
  int          m_lat  = 0;
  logic [31:0] m_last = '0;

  logic        e_stall, e_busy, e_done;
  logic [31:0] e_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int ia, ib;
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
      3'd2: begin p = longint'(ia) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
`ifdef EX_MUDIV_DIV_EN
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 33;
`ifdef EX_MUDIV_DIV_EN
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  // Model: m_age counts cycles since acceptance; done is due when m_age reaches the latency.
  always @(posedge clk) begin
    if (rst) begin
      m_age  = -1;
      m_last = '0;
      exp_q.delete();
    end else if (m_age < 0) begin
      if (bus.start && !bus.flush) begin
        exp_q.push_back(model_res(bus.op, bus.operand_a, bus.operand_b));
        m_lat = model_lat(bus.op, bus.operand_a, bus.operand_b);
        m_age = 1;
      end
    end else if (bus.flush) begin
      void'(exp_q.pop_front());
      m_age = -1;
    end else if (m_age == m_lat) begin
      m_last = exp_q.pop_front();
      m_age  = -1;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      e_res  = m_last;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (m_age < 0) begin
        e_stall = bus.start && !bus.flush;
      end else if (m_age < m_lat) begin
        e_stall = 1'b1;
        e_busy  = 1'b1;
      end else begin
        e_stall = 1'b0;
        e_done  = !bus.flush;
        if (e_done) e_res = exp_q[0];
      end
      chk("stall", bus.stall, e_stall);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("result", bus.result, e_res);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    int cyc;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b0;
    bus.op = op; bus.operand_a = a; bus.operand_b = b;
    cyc = 0; lat = -1; res = '0;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc;
        res = bus.result;
        break;
      end
      if (cyc >= 40) begin
        n_checks++; n_errors++;
        $display("FAIL timeout: no done after %0d cycles, op %0d", cyc, op);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      bus.op = 3'($urandom_range(0, 7));
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic [31:0] res;
    run_op(op, a, b, lat, res);
    chk({name, "_res"}, res, exp_res);
    chk({name, "_lat"}, lat, exp_lat);
  endtask

  task automatic kill_op(input logic use_rst, input int at_cycle, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b0;
    bus.op = op; bus.operand_a = a; bus.operand_b = b;
    repeat (at_cycle) begin @(posedge clk); #1; end
    if (use_rst) rst = 1'b1;
    else         bus.flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("kill_idle", bus.state, ST_IDLE);
    chk("kill_no_done", bus.done, 1'b0);
    if (use_rst) chk("kill_rst_result", bus.result, 32'h0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    logic [31:0] res, a, b;
    logic [2:0]  op;

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    bus.operand_a = '0; bus.operand_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", bus.state, ST_IDLE);
    chk("reset_result", bus.result, 32'h0);
    chk("reset_busy", bus.busy, 1'b0);

    check_op("mul_7xm3",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    check_op("mulhu_m1",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    check_op("mulh_m1",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    check_op("mulhsu_m1x2", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
`ifdef EX_MUDIV_DIV_EN
    check_op("div_m7_2",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    check_op("rem_m7_2",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    check_op("divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14,       33);
    check_op("remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2,        33);
    check_op("divu_by0",    3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    check_op("rem_by0",     3'd6, 32'd5,        32'd0,        32'd5,        1);
    check_op("div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
`else
    check_op("div_off",     3'd4, 32'd10,       32'd2,        32'h0,        1);
    check_op("remu_off",    3'd7, 32'd100,      32'd7,        32'h0,        1);
`endif

    kill_op(1'b0, 10, 3'd0, 32'd123, 32'd456);
    check_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 33);
    kill_op(1'b1, 10, 3'd0, 32'd123, 32'd456);
    check_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 33);
    kill_op(1'b0, 33, 3'd3, 32'hDEADBEEF, 32'h12345678);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_beats_start", bus.state, ST_IDLE);

    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, lat, res);
      chk("rand_lat", lat, model_lat(op, a, b));
      chk("rand_res", res, model_res(op, a, b));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      if ($urandom_range(0, 9) == 0)
        kill_op($urandom_range(0, 1) == 1, $urandom_range(1, 32), 3'($urandom_range(0, 3)), $urandom, $urandom);
    end

    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
